// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: dump sequencer states, NAK byte and default sizes.
package la_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT_TX,
        NAK_TX,
        DONE
    } state_t;

    localparam logic [7:0] NAK_BYTE    = 8'hEE;
    localparam int         DEF_ENTRIES = 384;
    localparam int         DEF_LOG2    = 9;
    localparam int         DEF_NUM_CH  = 5;

endpackage

// File: rtl/dump_ctrl.sv
// Channel dump sequencer: walks one capture RAM and streams each entry as a byte to the UART TX.
module dump_ctrl
    import la_pkg::*;
#(
    parameter int         ENTRIES = DEF_ENTRIES,
    parameter int         LOG2    = DEF_LOG2,
    parameter int         NUM_CH  = DEF_NUM_CH,
    parameter logic [7:0] NAK     = NAK_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dump_req,
    input  logic [2:0]          dump_ch,
    input  logic                capt_done,
    input  logic [8*NUM_CH-1:0] rdata,
    input  logic                last_rd,
    input  logic                tx_done,
    output logic                trmt,
    output logic [7:0]          tx_data,
    output logic                rd_adv,
    output logic [2:0]          ch_sel,
    output logic                busy,
    output logic                dump_done,
    output logic [LOG2-1:0]     byte_cnt
);

    state_t          state, state_d;
    logic            trmt_d;
    logic [7:0]      tx_data_d;
    logic [2:0]      ch_sel_d;
    logic            busy_d;
    logic            dump_done_d;
    logic [LOG2-1:0] byte_cnt_d;

    logic            accept;
    logic [7:0]      sel_byte;
    logic            at_guard;

    assign accept   = capt_done && (int'(dump_ch) < NUM_CH);
    assign sel_byte = rdata[int'(ch_sel)*8 +: 8];
    // Overrun guard: the entry being acknowledged is the last one the RAM can hold.
    assign at_guard = (byte_cnt == LOG2'(ENTRIES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            trmt      <= 1'b0;
            tx_data   <= 8'd0;
            ch_sel    <= 3'd0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            state     <= state_d;
            trmt      <= trmt_d;
            tx_data   <= tx_data_d;
            ch_sel    <= ch_sel_d;
            busy      <= busy_d;
            dump_done <= dump_done_d;
            byte_cnt  <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        trmt_d      = 1'b0;
        tx_data_d   = tx_data;
        ch_sel_d    = ch_sel;
        busy_d      = busy;
        dump_done_d = 1'b0;
        byte_cnt_d  = byte_cnt;
        rd_adv      = 1'b0;

        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (dump_req) begin
                    busy_d = 1'b1;
                    if (accept) begin
                        ch_sel_d   = dump_ch;
                        byte_cnt_d = '0;
                        state_d    = SETTLE;
                    end else begin
                        tx_data_d = NAK;
                        trmt_d    = 1'b1;
                        state_d   = NAK_TX;
                    end
                end
            end
            SETTLE: begin
                tx_data_d = sel_byte;
                trmt_d    = 1'b1;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    rd_adv = 1'b1;
                    if (byte_cnt != LOG2'(ENTRIES)) begin
                        byte_cnt_d = byte_cnt + LOG2'(1);
                    end
                    if (last_rd || at_guard) begin
                        dump_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            NAK_TX: begin
                if (tx_done) begin
                    dump_done_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
